// File: rtl/vle_pkg.sv
// vle_pkg: shared types and default parameters for vector_line_engine.
// Build option: define VLE_CLIP_EN to suppress off-screen pixels.
package vle_pkg;

   localparam int unsigned VLE_COORD_W    = 13;
   localparam int unsigned VLE_SCREEN_W   = 640;
   localparam int unsigned VLE_SCREEN_H   = 480;
   localparam int unsigned VLE_COLOR_W    = 4;
   localparam int unsigned VLE_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      STEP  = 2'd2,
      DONE  = 2'd3
   } vle_state_t;

   // One queued line: centred endpoints (+y up) and colour.
   typedef struct packed {
      logic signed [VLE_COORD_W-1:0] start_x;
      logic signed [VLE_COORD_W-1:0] start_y;
      logic signed [VLE_COORD_W-1:0] end_x;
      logic signed [VLE_COORD_W-1:0] end_y;
      logic        [VLE_COLOR_W-1:0] color;
   } vle_cmd_t;

endpackage

// File: rtl/vle_cmd_fifo.sv
// vle_cmd_fifo: synchronous first-word-fall-through queue of line commands.
module vle_cmd_fifo
   import vle_pkg::*;
#(
   parameter int unsigned DEPTH = VLE_FIFO_DEPTH
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  vle_cmd_t din,
   output vle_cmd_t dout,
   output logic     full,
   output logic     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   vle_cmd_t         mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   // Extra pointer bit distinguishes full from empty; low bits wrap modulo DEPTH.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign dout  = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update on accepted push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/vector_line_engine.sv
// vector_line_engine: queued Bresenham line rasteriser with a valid/ready pixel stream.
// Build option: VLE_CLIP_EN hides off-screen pixels while stepping continues through them.
module vector_line_engine
   import vle_pkg::*;
#(
   parameter int unsigned COORD_W    = VLE_COORD_W,
   parameter int unsigned SCREEN_W   = VLE_SCREEN_W,
   parameter int unsigned SCREEN_H   = VLE_SCREEN_H,
   parameter int unsigned COLOR_W    = VLE_COLOR_W,
   parameter int unsigned FIFO_DEPTH = VLE_FIFO_DEPTH,
   localparam int unsigned ADDR_W    = $clog2(SCREEN_W*SCREEN_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_start_x,
   input  logic [COORD_W-1:0] cmd_start_y,
   input  logic [COORD_W-1:0] cmd_end_x,
   input  logic [COORD_W-1:0] cmd_end_y,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W:0]   pix_x,
   output logic [COORD_W:0]   pix_y,
   output logic [ADDR_W-1:0]  pix_addr,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pix_onscreen,
   output logic               pix_last,
   output logic               line_done,
   output logic               busy
);

   localparam int unsigned SW = COORD_W + 2;   // screen-coordinate width
   localparam int unsigned EW = COORD_W + 3;   // delta / error width

   localparam logic signed [SW-1:0] HALF_W = SW'(SCREEN_W / 2);
   localparam logic signed [SW-1:0] HALF_H = SW'(SCREEN_H / 2);
   localparam logic signed [SW-1:0] SCR_W  = SW'(SCREEN_W);
   localparam logic signed [SW-1:0] SCR_H  = SW'(SCREEN_H);

   vle_state_t state_q, state_d;
   vle_cmd_t   cmd_in, fifo_head, cmd_q;
   logic       fifo_full, fifo_empty, push, pop;
   logic       adv, load, finish;

   logic signed [SW-1:0] cur_x, cur_y;
   logic signed [EW-1:0] dx_q, dy_q, err_q;
   logic        [EW-1:0] count_q;
   logic                 step_x_neg, step_y_neg;

   logic signed [SW-1:0] sx0, sy0, ex0, ey0;
   logic signed [EW-1:0] ddx, ddy, adx, ady, err0, cnt0;
   logic signed [EW:0]   e2, ndy;
   logic signed [SW-1:0] x_inc, y_inc, nx, ny;
   logic signed [EW-1:0] nerr;
   logic signed [SW-1:0] cand_x, cand_y;
   logic                 cand_end, cand_on, cand_vis;
   logic [ADDR_W-1:0]    cand_addr;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;
   assign busy      = (state_q != IDLE) || !fifo_empty;

   // Pack the incoming command for the queue.
   always_comb begin
      cmd_in         = '0;
      cmd_in.start_x = VLE_COORD_W'($signed(cmd_start_x));
      cmd_in.start_y = VLE_COORD_W'($signed(cmd_start_y));
      cmd_in.end_x   = VLE_COORD_W'($signed(cmd_end_x));
      cmd_in.end_y   = VLE_COORD_W'($signed(cmd_end_y));
      cmd_in.color   = VLE_COLOR_W'(cmd_color);
   end

   vle_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (cmd_in),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state plus datapath strobes; a hidden (clipped) pixel advances without a handshake.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      adv     = 1'b0;
      load    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            load    = 1'b1;
            state_d = STEP;
         end
         STEP: begin
            adv = !pix_valid || pix_ready;
            if (adv && (count_q == '0)) begin
               finish  = 1'b1;
               state_d = DONE;
            end else if (adv) begin
               load = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Line geometry from the popped command, in screen coordinates (+y down).
   always_comb begin
      sx0  = HALF_W + SW'(cmd_q.start_x);
      sy0  = HALF_H - SW'(cmd_q.start_y);
      ex0  = HALF_W + SW'(cmd_q.end_x);
      ey0  = HALF_H - SW'(cmd_q.end_y);
      ddx  = EW'(ex0) - EW'(sx0);
      ddy  = EW'(ey0) - EW'(sy0);
      adx  = ddx[EW-1] ? -ddx : ddx;
      ady  = ddy[EW-1] ? -ddy : ddy;
      err0 = adx - ady;
      cnt0 = (adx >= ady) ? adx : ady;
   end

   // One Bresenham step from the current pixel.
   always_comb begin
      e2    = {err_q, 1'b0};
      ndy   = -((EW+1)'(dy_q));
      x_inc = step_x_neg ? SW'(-1) : SW'(1);
      y_inc = step_y_neg ? SW'(-1) : SW'(1);
      nx    = cur_x;
      ny    = cur_y;
      nerr  = err_q;
      if (e2 > ndy) begin
         nerr = nerr - dy_q;
         nx   = nx + x_inc;
      end
      if (e2 < (EW+1)'(dx_q)) begin
         nerr = nerr + dx_q;
         ny   = ny + y_inc;
      end
   end

   // Candidate pixel to be registered onto the output: the start point in SETUP, else the next step.
   always_comb begin
      if (state_q == SETUP) begin
         cand_x   = sx0;
         cand_y   = sy0;
         cand_end = (cnt0 == '0);
      end else begin
         cand_x   = nx;
         cand_y   = ny;
         cand_end = (count_q == EW'(1));
      end
      cand_on   = !cand_x[SW-1] && (cand_x < SCR_W) && !cand_y[SW-1] && (cand_y < SCR_H);
      cand_addr = cand_on ? (ADDR_W'(cand_y) * ADDR_W'(SCREEN_W) + ADDR_W'(cand_x)) : '0;
`ifdef VLE_CLIP_EN
      cand_vis  = cand_on;
`else
      cand_vis  = 1'b1;
`endif
   end

   // Datapath and registered pixel outputs; stalled pixels hold because nothing loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q        <= '0;
         cur_x        <= '0;
         cur_y        <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         err_q        <= '0;
         count_q      <= '0;
         step_x_neg   <= 1'b0;
         step_y_neg   <= 1'b0;
         pix_valid    <= 1'b0;
         pix_x        <= '0;
         pix_y        <= '0;
         pix_addr     <= '0;
         pix_color    <= '0;
         pix_onscreen <= 1'b0;
         pix_last     <= 1'b0;
         line_done    <= 1'b0;
      end else begin
         line_done <= (state_d == DONE);
         if (pop) cmd_q <= fifo_head;
         if (load) begin
            if (state_q == SETUP) begin
               dx_q       <= adx;
               dy_q       <= ady;
               err_q      <= err0;
               count_q    <= cnt0;
               step_x_neg <= ddx[EW-1];
               step_y_neg <= ddy[EW-1];
               pix_color  <= COLOR_W'(cmd_q.color);
            end else begin
               err_q   <= nerr;
               count_q <= count_q - EW'(1);
            end
            cur_x        <= cand_x;
            cur_y        <= cand_y;
            pix_x        <= (COORD_W+1)'(cand_x);
            pix_y        <= (COORD_W+1)'(cand_y);
            pix_addr     <= cand_addr;
            pix_onscreen <= cand_on;
            pix_valid    <= cand_vis;
            pix_last     <= cand_end && cand_vis;
         end else if (finish) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vector_line_engine.sv
// tb_vector_line_engine: directed self-checking bench for vector_line_engine at default parameters.
module tb_vector_line_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [12:0] cmd_start_x = '0, cmd_start_y = '0, cmd_end_x = '0, cmd_end_y = '0;
   logic [3:0]  cmd_color = '0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [13:0] pix_x, pix_y;
   logic [18:0] pix_addr;
   logic [3:0]  pix_color;
   logic        pix_onscreen, pix_last, line_done, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int px [64];
   int py [64];
   int pa [64];
   int pon [64];
   int pl [64];
   int pc [64];
   int pcyc [64];

   vector_line_engine dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_start_x  (cmd_start_x),
      .cmd_start_y  (cmd_start_y),
      .cmd_end_x    (cmd_end_x),
      .cmd_end_y    (cmd_end_y),
      .cmd_color    (cmd_color),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_addr     (pix_addr),
      .pix_color    (pix_color),
      .pix_onscreen (pix_onscreen),
      .pix_last     (pix_last),
      .line_done    (line_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_cmd(input int sx, input int sy, input int ex, input int ey, input int col);
      cmd_start_x = 13'(sx);
      cmd_start_y = 13'(sy);
      cmd_end_x   = 13'(ex);
      cmd_end_y   = 13'(ey);
      cmd_color   = 4'(col);
   endtask

   // Offer one command and return just after the edge that accepted it.
   task automatic push_cmd(input int sx, input int sy, input int ex, input int ey, input int col);
      int guard = 0;
      set_cmd(sx, sy, ex, ey, col);
      cmd_valid = 1'b1;
      while (!cmd_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!cmd_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Drive pix_ready (mode 0: always, mode 1: every third cycle) and record handshaken pixels until line_done.
   task automatic run_line(input int mode, input int max_cyc, output int npix, output int ndone,
                           output int nstall, output int first_v, output int last_hs, output int done_cyc);
      logic        hold = 1'b0;
      logic [55:0] held = '0;
      logic [55:0] now_v;
      npix = 0; ndone = 0; nstall = 0; first_v = -1; last_hs = -1; done_cyc = -1;
      for (int c = 0; c < max_cyc; c++) begin
         pix_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
         now_v = {pix_valid, pix_x, pix_y, pix_addr, pix_color, pix_onscreen, pix_last};
         if (hold && (now_v !== held)) nstall++;
         if (pix_valid && first_v < 0) first_v = c;
         if (line_done) begin ndone++; done_cyc = c; end
         if (pix_valid && pix_ready && npix < 64) begin
            px[npix]  = int'($signed(pix_x));
            py[npix]  = int'($signed(pix_y));
            pa[npix]  = int'(pix_addr);
            pon[npix] = int'(pix_onscreen);
            pl[npix]  = int'(pix_last);
            pc[npix]  = int'(pix_color);
            npix++;
            last_hs = c;
         end
         hold = pix_valid && !pix_ready;
         held = now_v;
         @(posedge clk); #1;
         if (ndone > 0) break;
      end
      pix_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; pix_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid: got %0b want 0", pix_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
      n_cmp++;
      if ({pix_last, line_done, pix_x, pix_y, pix_addr, pix_color, pix_onscreen} !== 54'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", {pix_last, line_done, pix_x, pix_y, pix_addr, pix_color, pix_onscreen});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_line();
      int ex [4] = '{320, 321, 322, 323};
      int ey [4] = '{240, 240, 239, 239};
      int np, nd, ns, fv, lh, dc;
      push_cmd(0, 0, 3, 1, 5);
      n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_cycle: pix_valid=%0b want 0", pix_valid); end
      run_line(0, 40, np, nd, ns, fv, lh, dc);
      n_cmp++; if (np !== 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", np); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (px[i] !== ex[i] || py[i] !== ey[i] || pl[i] !== int'(i == 3) || pc[i] !== 5) begin
            n_bad++;
            $display("FAIL basic_pix%0d: got (%0d,%0d) last=%0d col=%0d want (%0d,%0d) last=%0d col=5",
                     i, px[i], py[i], pl[i], pc[i], ex[i], ey[i], int'(i == 3));
         end
      end
      n_cmp++; if (fv !== 2) begin n_bad++; $display("FAIL basic_latency: first valid at %0d want 2", fv); end
      n_cmp++; if (nd !== 1 || dc !== lh + 1) begin n_bad++; $display("FAIL basic_done: pulses=%0d at %0d want 1 at %0d", nd, dc, lh + 1); end
      n_cmp++; if (line_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %0b want 0", line_done); end
   endtask

   task automatic test_zero_length();
      int np, nd, ns, fv, lh, dc;
      push_cmd(10, 10, 10, 10, 9);
      run_line(0, 40, np, nd, ns, fv, lh, dc);
      n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL zero_count: got %0d want 1", np); end
      n_cmp++;
      if (px[0] !== 330 || py[0] !== 230) begin
         n_bad++; $display("FAIL zero_xy: got (%0d,%0d) want (330,230)", px[0], py[0]);
      end
      n_cmp++; if (pa[0] !== 147530) begin n_bad++; $display("FAIL zero_addr: got %0d want 147530", pa[0]); end
      n_cmp++; if (pl[0] !== 1 || pon[0] !== 1) begin n_bad++; $display("FAIL zero_flags: last=%0d on=%0d want 1 1", pl[0], pon[0]); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL zero_done: got %0d want 1", nd); end
   endtask

   task automatic test_stall();
      int np, nd, ns, fv, lh, dc;
      push_cmd(5, -5, -5, 5, 3);
      run_line(1, 200, np, nd, ns, fv, lh, dc);
      n_cmp++; if (np !== 11) begin n_bad++; $display("FAIL stall_count: got %0d want 11", np); end
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (px[i] !== 325 - i || py[i] !== 245 - i) begin
            n_bad++;
            $display("FAIL stall_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], 325 - i, 245 - i);
         end
      end
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL stall_hold: %0d unstable stall cycles want 0", ns); end
      n_cmp++; if (pl[10] !== 1 || nd !== 1) begin n_bad++; $display("FAIL stall_end: last=%0d done=%0d want 1 1", pl[10], nd); end
   endtask

   task automatic test_back_to_back();
      int  idx = 0;
      int  nd = 0;
      int  np = 0;
      logic hs_cmd;
      pix_ready = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c == 10) pix_ready = 1'b1;
         if (c == 8) begin
            n_cmp++; if (idx !== 5) begin n_bad++; $display("FAIL b2b_accepted: got %0d want 5", idx); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %0b want 0", cmd_ready); end
         end
         if (idx < 6) begin
            set_cmd(2 * idx, 0, 2 * idx + 1, 0, idx + 1);
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         hs_cmd = cmd_valid && cmd_ready;
         if (line_done) nd++;
         if (pix_valid && pix_ready && np < 64) begin
            px[np] = int'($signed(pix_x));
            pc[np] = int'(pix_color);
            pcyc[np] = c;
            np++;
         end
         @(posedge clk); #1;
         if (hs_cmd) idx++;
         if (nd == 6 && idx == 6) break;
      end
      cmd_valid = 1'b0;
      n_cmp++; if (nd !== 6 || np !== 12) begin n_bad++; $display("FAIL b2b_totals: lines=%0d pixels=%0d want 6 12", nd, np); end
      for (int i = 0; i < 12; i++) begin
         n_cmp++;
         if (px[i] !== 320 + i || pc[i] !== i / 2 + 1) begin
            n_bad++;
            $display("FAIL b2b_pix%0d: got x=%0d col=%0d want x=%0d col=%0d", i, px[i], pc[i], 320 + i, i / 2 + 1);
         end
      end
      for (int k = 1; k < 6; k++) begin
         n_cmp++;
         if (pcyc[2 * k] - pcyc[2 * k - 1] !== 4) begin
            n_bad++;
            $display("FAIL b2b_gap%0d: got %0d cycles want 4", k, pcyc[2 * k] - pcyc[2 * k - 1]);
         end
      end
   endtask

   task automatic test_offscreen();
      int np, nd, ns, fv, lh, dc;
      int bad_pix = 0;
      int nlast = 0;
      push_cmd(300, 0, 340, 0, 7);
      run_line(0, 200, np, nd, ns, fv, lh, dc);
`ifdef VLE_CLIP_EN
      n_cmp++; if (np !== 20) begin n_bad++; $display("FAIL clip_count: got %0d want 20", np); end
      for (int i = 0; i < 20; i++) begin
         if (px[i] !== 620 + i || py[i] !== 240 || pon[i] !== 1) bad_pix++;
         if (pl[i] !== 0) nlast++;
      end
      n_cmp++; if (bad_pix !== 0) begin n_bad++; $display("FAIL clip_pixels: %0d wrong want 0", bad_pix); end
      n_cmp++; if (nlast !== 0) begin n_bad++; $display("FAIL clip_last: %0d flagged want 0", nlast); end
`else
      n_cmp++; if (np !== 41) begin n_bad++; $display("FAIL offscr_count: got %0d want 41", np); end
      for (int i = 0; i < 41; i++) begin
         if (px[i] !== 620 + i || py[i] !== 240 || pon[i] !== int'(i < 20)) bad_pix++;
         if (pl[i] !== int'(i == 40)) nlast++;
      end
      n_cmp++; if (bad_pix !== 0) begin n_bad++; $display("FAIL offscr_pixels: %0d wrong want 0", bad_pix); end
      n_cmp++; if (nlast !== 0) begin n_bad++; $display("FAIL offscr_last: %0d wrong flags want 0", nlast); end
`endif
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL offscr_done: got %0d want 1", nd); end
   endtask

   task automatic test_reset_mid_line();
      int n = 0;
      int found = 0;
      int extra_v = 0;
      int extra_d = 0;
      int extra_b = 0;
      pix_ready = 1'b1;
      push_cmd(0, 0, 19, 0, 2);
      push_cmd(0, 5, 0, 6, 3);
      for (int c = 0; c < 20; c++) begin
         if (pix_valid) n++;
         if (n == 3) begin found = 1; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (found !== 1 || pix_x !== 14'd322) begin n_bad++; $display("FAIL rstmid_third: found=%0d x=%0d want 1 322", found, pix_x); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({pix_valid, pix_last, line_done, busy, cmd_ready, pix_x, pix_y, pix_addr, pix_color, pix_onscreen}
          !== {4'b0000, 1'b1, 52'd0}) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %h want %h",
                  {pix_valid, pix_last, line_done, busy, cmd_ready, pix_x, pix_y, pix_addr, pix_color, pix_onscreen},
                  {4'b0000, 1'b1, 52'd0});
      end
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (pix_valid) extra_v++;
         if (line_done) extra_d++;
         if (busy) extra_b++;
      end
      n_cmp++;
      if (extra_v !== 0 || extra_d !== 0 || extra_b !== 0) begin
         n_bad++;
         $display("FAIL rstmid_quiet: valid=%0d done=%0d busy=%0d cycles want 0 0 0", extra_v, extra_d, extra_b);
      end
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_zero_length();
      test_stall();
      test_back_to_back();
      test_offscreen();
      test_reset_mid_line();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
